led_row_scanner: RTL and testbench

- Sequential stage directly upstream of decoder_3_to_8 in the Game of Life display path.
- Holds one 8x8 frame and scans it row by row. Drives the decoder's ena and in from row_ena and row_sel, and drives the column lines from col_data.
- Inserts a blanking gap between rows to suppress ghosting.
- Accepts a new frame from the life engine only at a frame boundary, through a valid/ready handshake, so the display never shows a torn frame.

---
 rtl/led_matrix_pkg.sv | 15 +
 rtl/led_row_scanner.sv | 103 ++++++++++
 tb/tb_led_row_scanner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and sizes for the LED matrix display path.
package led_matrix_pkg;

    localparam int N_ROWS = 8;
    localparam int N_COLS = 8;
    localparam int ROW_W  = 3;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    typedef logic [N_ROWS*N_COLS-1:0] frame_t;

endpackage

// File: rtl/led_row_scanner.sv
// Row scanner for an 8x8 LED matrix: buffers one frame and drives it row by
// row with a blanking gap before each row. New frames are only accepted in
// the blank window ahead of row 0, so a frame is never displayed torn.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_BLANK | row_ena low, columns dark; latch next row's columns at end
//  S_DRIVE | row_ena high, registered columns driven for ROW_TICKS cycles
module led_row_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [63:0]            frame_in,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic                   row_ena,
    output logic [ROW_W-1:0]       row_sel,
    output logic [N_COLS-1:0]      col_data,
    output logic                   frame_start
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(ROW_TICKS - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [ROW_W-1:0]     r_row_sel;
    logic [N_COLS-1:0]    r_col_data;
    logic                 r_frame_start;
    frame_t               r_buf;

    logic                 w_blank_last;
    logic                 w_drive_last;
    logic                 w_load;
    frame_t               w_src;

    assign w_blank_last = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
    assign w_drive_last = (r_state == S_DRIVE) && (r_cnt == DRIVE_LAST);
    assign frame_ready  = (r_state == S_BLANK) && (r_row_sel == '0) && rst_n;
    assign w_load       = frame_valid && frame_ready;
    // A transfer on the last blank cycle must reach row 0 immediately.
    assign w_src        = w_load ? frame_in : r_buf;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode from the tick counter terminal counts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BLANK: if (w_blank_last) w_state_next = S_DRIVE;
            S_DRIVE: if (w_drive_last) w_state_next = S_BLANK;
            default: w_state_next = S_BLANK;
        endcase
    end

    // Tick counter, frame buffer, row index and registered column drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_buf         <= '0;
            r_row_sel     <= '0;
            r_col_data    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_load) begin
                r_buf <= frame_in;
            end
            if (w_blank_last) begin
                r_col_data <= w_src[int'(r_row_sel)*N_COLS +: N_COLS];
            end else if (w_drive_last) begin
                r_col_data <= '0;
            end
            r_frame_start <= w_blank_last && (r_row_sel == '0);
            if (w_drive_last) begin
                r_row_sel <= r_row_sel + 1'b1;
            end
        end
    end

    // Outputs decode straight from registers so the decoder sees no glitches.
    always_comb begin
        row_ena     = (r_state == S_DRIVE);
        row_sel     = r_row_sel;
        col_data    = r_col_data;
        frame_start = r_frame_start;
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// Bench for led_row_scanner with ROW_TICKS=3, BLANK_TICKS=2, checked against
// a position-in-frame reference model.
module tb_led_row_scanner;

    localparam int RT     = 3;
    localparam int BT     = 2;
    localparam int SLOT   = RT + BT;
    localparam int PERIOD = 8 * SLOT;
    localparam logic [63:0] DIAG = 64'h8040201008040201;

    logic        clk;
    logic        rst_n;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        row_ena;
    logic [2:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_start;
    logic [7:0]  dec_out;

    int n_checks = 0;
    int n_errors = 0;

    led_row_scanner #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_ena     (row_ena),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    // Behavioural stand-in for the downstream 3-to-8 decoder.
    assign dec_out = row_ena ? (8'h01 << row_sel) : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: m_t is the cycle position since the last reset edge,
    // m_buf the frame the engine has handed over.
    int          m_t    = 0;
    logic [63:0] m_buf  = '0;
    bit          m_live = 1'b0;
    int          cyc    = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_t    = 0;
            m_buf  = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (frame_valid && (m_t % PERIOD) < BT) m_buf = frame_in;
            m_t++;
        end
    end

    int pos, row, ph, last_fs;
    bit drive;
    logic [7:0] exp_col, exp_dec;

    initial last_fs = -1;

    always @(negedge clk) begin
        if (m_live) begin
            pos     = m_t % PERIOD;
            row     = pos / SLOT;
            ph      = pos % SLOT;
            drive   = (ph >= BT);
            exp_col = drive ? m_buf[8*row +: 8] : 8'h00;
            exp_dec = drive ? (8'h01 << row) : 8'h00;
            check("row_sel",     64'(row_sel),     64'(row));
            check("row_ena",     64'(row_ena),     64'(drive));
            check("col_data",    64'(col_data),    64'(exp_col));
            check("frame_start", 64'(frame_start), 64'(drive && row == 0 && ph == BT));
            check("frame_ready", 64'(frame_ready), 64'(rst_n && pos < BT));
            check("decoder",     64'(dec_out),     64'(exp_dec));
            if (m_t == 0) last_fs = -1;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("fs_period", 64'(cyc - last_fs), 64'(PERIOD));
                last_fs = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while ((m_t % PERIOD) != p && n < 2 * PERIOD) begin
            tick();
            n++;
        end
        check("wait_pos", 64'(m_t % PERIOD), 64'(p));
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b1;
        frame_in    = {$urandom, $urandom};
        repeat (5) tick();

        // Diagonal frame offered across the first blank window.
        rst_n    = 1'b1;
        frame_in = DIAG;
        tick();
        tick();
        frame_valid = 1'b0;
        repeat (2 * PERIOD) tick();

        // Late frame raised during row 3 drive, held until accepted.
        wait_pos(3 * SLOT + BT);
        frame_valid = 1'b1;
        frame_in    = '1;
        wait_pos(BT);
        frame_valid = 1'b0;

        // Bypass: valid only on the last blank cycle ahead of row 0.
        wait_pos(0);
        tick();
        frame_valid = 1'b1;
        frame_in    = {$urandom, $urandom_range(0, 16777215), 8'hA5};
        tick();
        frame_valid = 1'b0;

        // One-cycle reset during row 5 drive, then a dark frame.
        wait_pos(5 * SLOT + BT + 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (PERIOD + 5) tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            frame_valid = 1'($urandom_range(0, 1));
            frame_in    = {$urandom, $urandom};
            rst_n       = ($urandom_range(0, 249) != 0);
            tick();
        end
        rst_n       = 1'b1;
        frame_valid = 1'b0;
        repeat (PERIOD) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
